tcp_tx_frame_arbiter: RTL and testbench

- Shares the single SiTCP TCP TX byte path (TX FIFO write port: data byte plus write enable, backpressured by the FIFO prog_full flag) among N_REQ data sources, for example TDC channel readouts.
- Grants one whole frame at a time, round-robin.
- Wraps each frame as header (sync byte, {source ID, sequence}), then payload, then a 16-bit byte-count trailer.
- Sits between the user data sources and the TX FIFO write side of the SiTCP wrapper.

---
 rtl/tcp_tx_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/tcp_tx_frame_arbiter.sv | 150 +++++++++++++++
 tb/tb_tcp_tx_frame_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_tx_pkg.sv
// Shared types and constants for the SiTCP TX frame arbiter.
package tcp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_TRL0,
    ST_TRL1,
    ST_FLUSH
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned HDR_LEN = 2;
  localparam int unsigned TRL_LEN = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_id, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [3:0]       last_id,
  output logic [3:0]       gnt_id,
  output logic             any_req
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  int unsigned cand;

  always_comb begin
    gnt_id  = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_id) + k) % N_REQ;
      if (!any_req && req[cand[IW-1:0]]) begin
        any_req = 1'b1;
        gnt_id  = 4'(cand);
      end
    end
  end

endmodule

// File: rtl/tcp_tx_frame_arbiter.sv
// Frames bytes from N_REQ sources onto the single SiTCP TX FIFO write port,
// one whole frame per round-robin grant: sync, {id,seq}, payload, 16-bit count.
module tcp_tx_frame_arbiter
  import tcp_tx_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                 CLK_200M,
  input  logic                 SYS_RSTn,
  input  logic                 LINK_UP,
  input  logic                 FIFO_FULL,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [N_REQ-1:0]     REQ_LAST,
  input  logic [8*N_REQ-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]     REQ_READY,
  output logic [7:0]           TX_DATA,
  output logic                 TX_EN,
  output logic [3:0]           GRANT,
  output logic                 BUSY,
  output logic [15:0]          DROP_CNT
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d, arb_id;
  logic        any_req;
  logic [15:0] cnt_q, cnt_d, drop_q, drop_d;
  logic [3:0]  seq_q [N_REQ];
  logic        seq_inc, emit, step;
  logic [7:0]  emit_data, tx_data_q;
  logic        tx_en_q;
  logic [IW-1:0] gidx;
  logic [7:0]  req_byte [N_REQ];

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (REQ_VALID),
    .last_id (grant_q),
    .gnt_id  (arb_id),
    .any_req (any_req)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) req_byte[i] = REQ_DATA[8*i +: 8];
  end

  assign step = LINK_UP && !FIFO_FULL;
  assign gidx = grant_q[IW-1:0];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    seq_inc   = 1'b0;
    emit      = 1'b0;
    emit_data = '0;
    REQ_READY = '0;
    case (state_q)
      ST_IDLE: begin
        if (LINK_UP && any_req) begin
          grant_d = arb_id;
          cnt_d   = '0;
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (!LINK_UP) state_d = ST_IDLE;
        else if (step) begin
          emit      = 1'b1;
          emit_data = SYNC_BYTE;
          state_d   = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (!LINK_UP) state_d = ST_IDLE;
        else if (step) begin
          emit      = 1'b1;
          emit_data = {grant_q, seq_q[gidx]};
          seq_inc   = 1'b1;
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!LINK_UP) begin
          state_d = ST_FLUSH;
          if (drop_q != '1) drop_d = drop_q + 16'd1;
        end else begin
          REQ_READY[gidx] = step;
          if (REQ_VALID[gidx] && step) begin
            emit      = 1'b1;
            emit_data = req_byte[gidx];
            if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
            if (REQ_LAST[gidx]) state_d = ST_TRL0;
          end
        end
      end
      ST_TRL0: begin
        if (!LINK_UP) state_d = ST_IDLE;
        else if (step) begin
          emit      = 1'b1;
          emit_data = cnt_q[15:8];
          state_d   = ST_TRL1;
        end
      end
      ST_TRL1: begin
        if (!LINK_UP) state_d = ST_IDLE;
        else if (step) begin
          emit      = 1'b1;
          emit_data = cnt_q[7:0];
          state_d   = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Drain the granted source unconditionally so it never hangs mid-frame.
        REQ_READY[gidx] = 1'b1;
        if (REQ_VALID[gidx] && REQ_LAST[gidx]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q   <= ST_IDLE;
      grant_q   <= 4'(N_REQ - 1);
      cnt_q     <= '0;
      drop_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) seq_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      tx_en_q <= emit;
      if (emit) tx_data_q <= emit_data;
      if (seq_inc) seq_q[gidx] <= seq_q[gidx] + 4'd1;
    end
  end

  assign TX_EN    = tx_en_q;
  assign TX_DATA  = tx_data_q;
  assign GRANT    = grant_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_tcp_tx_frame_arbiter.sv
// Randomized and directed bench for tcp_tx_frame_arbiter against a frame-queue model.
`timescale 1ns/100ps
module tb_tcp_tx_frame_arbiter;

  localparam int N = 4;

  logic           CLK_200M = 1'b0;
  logic           SYS_RSTn = 1'b0;
  logic           LINK_UP = 1'b0;
  logic           FIFO_FULL = 1'b0;
  logic [N-1:0]   REQ_VALID = '0;
  logic [N-1:0]   REQ_LAST = '0;
  logic [8*N-1:0] REQ_DATA = '0;
  logic [N-1:0]   REQ_READY;
  logic [7:0]     TX_DATA;
  logic           TX_EN;
  logic [3:0]     GRANT;
  logic           BUSY;
  logic [15:0]    DROP_CNT;

  tcp_tx_frame_arbiter #(.N_REQ(N), .SYNC_BYTE(8'hA5)) dut (
    .CLK_200M (CLK_200M),
    .SYS_RSTn (SYS_RSTn),
    .LINK_UP  (LINK_UP),
    .FIFO_FULL(FIFO_FULL),
    .REQ_VALID(REQ_VALID),
    .REQ_LAST (REQ_LAST),
    .REQ_DATA (REQ_DATA),
    .REQ_READY(REQ_READY),
    .TX_DATA  (TX_DATA),
    .TX_EN    (TX_EN),
    .GRANT    (GRANT),
    .BUSY     (BUSY),
    .DROP_CNT (DROP_CNT)
  );

  always #2.5 CLK_200M = ~CLK_200M;

  int checks = 0, errors = 0;
  logic [8:0] src_q [N][$];
  logic [8:0] mdl_q [N][$];
  bit         started [N];
  int         m_last;
  logic [3:0] m_seq [N];
  logic [7:0] exp_q[$], tx_q[$];
  bit ff_rand = 0, ff_force = 0, gap_en = 0, ff_at_edge = 0;
  int ready_viol = 0, tx_viol = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source drivers: present queue head, optional gaps inside a started frame.
  always begin
    @(negedge CLK_200M);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !(gap_en && started[i] && $urandom_range(3) == 0)) begin
        REQ_VALID[i]       = 1'b1;
        REQ_DATA[8*i +: 8] = src_q[i][0][7:0];
        REQ_LAST[i]        = src_q[i][0][8];
      end else begin
        REQ_VALID[i] = 1'b0;
        REQ_LAST[i]  = 1'b0;
      end
    end
    FIFO_FULL = ff_rand ? ($urandom_range(2) == 0) : ff_force;
    #2;
    ff_at_edge = FIFO_FULL;
    if (LINK_UP && FIFO_FULL && REQ_READY != '0) ready_viol++;
    for (int i = 0; i < N; i++) begin
      if (REQ_VALID[i] && REQ_READY[i]) begin
        started[i] = !src_q[i][0][8];
        void'(src_q[i].pop_front());
      end
    end
  end

  always @(negedge CLK_200M) begin
    if (TX_EN) begin
      tx_q.push_back(TX_DATA);
      if (ff_at_edge) tx_viol++;
    end
  end

  task automatic push_byte(input int s, input logic [7:0] d, input bit last, input bit model);
    src_q[s].push_back({last, d});
    if (model) mdl_q[s].push_back({last, d});
  endtask

  task automatic add_frame(input int s, input int len);
    for (int k = 0; k < len; k++) push_byte(s, 8'($urandom), k == len - 1, 1'b1);
  endtask

  // Reference: serve pending frames round-robin, emit whole framed byte lists.
  task automatic model_run();
    int g, len;
    bit found;
    logic [8:0] b;
    forever begin
      found = 0;
      g = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && mdl_q[(m_last + k) % N].size() > 0) begin
          found = 1;
          g = (m_last + k) % N;
        end
      end
      if (!found) break;
      exp_q.push_back(8'hA5);
      exp_q.push_back({4'(g), m_seq[g]});
      m_seq[g] = m_seq[g] + 4'd1;
      len = 0;
      do begin
        b = mdl_q[g].pop_front();
        exp_q.push_back(b[7:0]);
        len++;
      end while (!b[8]);
      if (len > 65535) len = 65535;
      exp_q.push_back(8'(len >> 8));
      exp_q.push_back(8'(len));
      m_last = g;
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    bit pend;
    do begin
      pend = BUSY;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pend = 1;
      if (pend) begin
        @(negedge CLK_200M);
        n++;
      end
    end while (pend && n < bound);
    chk("done_in_time", 32'(n < bound), 32'd1);
    repeat (3) @(negedge CLK_200M);
  endtask

  task automatic check_stream(input string tag);
    int m;
    model_run();
    chk({tag, "_len"}, tx_q.size(), exp_q.size());
    m = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_byte"}, 32'(tx_q[i]), 32'(exp_q[i]));
    chk({tag, "_ready_while_full"}, ready_viol, 0);
    chk({tag, "_tx_while_full"}, tx_viol, 0);
    chk({tag, "_busy_end"}, 32'(BUSY), 0);
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_src_size(input int s, input int sz, input int bound);
    int n = 0;
    while (src_q[s].size() > sz && n < bound) begin
      @(posedge CLK_200M);
      n++;
    end
    chk("src_progress", 32'(n < bound), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_en"}, 32'(TX_EN), 0);
    chk({tag, "_tx_data"}, 32'(TX_DATA), 0);
    chk({tag, "_grant"}, 32'(GRANT), N - 1);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_drop"}, 32'(DROP_CNT), 0);
    chk({tag, "_ready"}, 32'(REQ_READY), 0);
  endtask

  initial begin
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_seq[i] = '0;
    repeat (3) @(negedge CLK_200M);
    #1 check_reset_outputs("rst");
    @(negedge CLK_200M);
    SYS_RSTn = 1'b1;
    LINK_UP  = 1'b1;

    // Basic frame from source 1 and a back-to-back second frame.
    @(posedge CLK_200M);
    push_byte(1, 8'h11, 0, 1);
    push_byte(1, 8'h22, 0, 1);
    push_byte(1, 8'h33, 1, 1);
    push_byte(1, 8'h44, 1, 1);
    wait_done(200);
    check_stream("basic");
    chk("basic_grant", 32'(GRANT), 1);

    // FIFO_FULL held five cycles mid-payload.
    @(posedge CLK_200M);
    add_frame(2, 4);
    wait_src_size(2, 2, 100);
    @(posedge CLK_200M);
    ff_force = 1;
    repeat (5) @(posedge CLK_200M);
    ff_force = 0;
    wait_done(200);
    check_stream("full");

    // Randomized frames, gaps and backpressure across all sources.
    @(posedge CLK_200M);
    gap_en  = 1;
    ff_rand = 1;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < N; s++) add_frame(s, $urandom_range(1, 20));
    wait_done(4000);
    gap_en  = 0;
    ff_rand = 0;
    check_stream("rand");

    // Link loss after two payload bytes of a six-byte frame.
    @(posedge CLK_200M);
    for (int k = 0; k < 6; k++) push_byte(0, 8'(8'hC0 + k), k == 5, 1'b0);
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'd0, m_seq[0]});
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    m_seq[0] = m_seq[0] + 4'd1;
    m_last = 0;
    wait_src_size(0, 4, 100);
    @(negedge CLK_200M);
    LINK_UP = 1'b0;
    wait_done(100);
    chk("flush_drop", 32'(DROP_CNT), 1);
    chk("flush_src_empty", src_q[0].size(), 0);
    check_stream("flush");
    add_frame(2, 3);
    repeat (10) @(negedge CLK_200M);
    chk("linkdown_busy", 32'(BUSY), 0);
    chk("linkdown_tx", tx_q.size(), 0);
    LINK_UP = 1'b1;
    wait_done(200);
    check_stream("relink");

    // Saturating byte count.
    @(posedge CLK_200M);
    add_frame(3, 70000);
    wait_done(75000);
    check_stream("sat");

    // Asynchronous reset in the middle of a payload.
    @(posedge CLK_200M);
    add_frame(1, 10);
    wait_src_size(1, 6, 100);
    @(negedge CLK_200M);
    #1 SYS_RSTn = 1'b0;
    #0.5 check_reset_outputs("midrst");
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
      started[i] = 0;
      m_seq[i] = '0;
    end
    m_last = N - 1;
    repeat (2) @(negedge CLK_200M);
    tx_q.delete();
    exp_q.delete();
    SYS_RSTn = 1'b1;
    @(posedge CLK_200M);
    for (int f = 0; f < 2; f++) begin
      add_frame(0, 1);
      add_frame(2, 1);
      add_frame(3, 1);
    end
    wait_done(200);
    check_stream("rr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
